id_ex_pipeline_reg: RTL and testbench

//  ID/EX pipeline register of the 5-stage RV32I core. Captures decoded instruction, operands,

---
 rtl/id_ex_pipeline_reg.sv | 152 +++++++++++++++
 tb/tb_id_ex_pipeline_reg.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipeline_reg.sv
// -----------------------------------------------------------------------------
// id_ex_pipeline_reg
//
// ID/EX pipeline register of the 5-stage RV32I core. It captures the decoded
// instruction, operands, immediate and control bits at the end of ID and
// presents them to EX one cycle later. It supports stall (hold), flush
// (bubble insert) and a valid bit, and counts inserted bubbles.
//
// Every update happens on posedge clk with priority reset > flush > stall > load.
// All outputs come straight from registers, so no input reaches an output
// through combinational logic.
//
// Ports
//   clk          : clock
//   reset        : synchronous, active-high reset
//   id_valid     : ID holds a real instruction this cycle
//   id_inst      : instruction word from IF/ID
//   id_pc        : PC of the ID instruction
//   id_rs1_data  : register file read data, port 1
//   id_rs2_data  : register file read data, port 2
//   id_imm       : sign-extended immediate
//   id_rd        : destination register index
//   id_ctrl      : {is_halted, reg_write, mem_to_reg, mem_write, mem_read, alu_src}
//   stall        : hold current contents
//   flush        : replace contents with a bubble
//   ex_valid     : EX holds a real instruction
//   ex_inst      : latched instruction (drives the ALU control unit)
//   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm : latched datapath fields
//   ex_rs1/ex_rs2: source register indices taken from ex_inst
//   ex_rd        : latched destination register index
//   ex_ctrl      : latched control bits, same order as id_ctrl
//   bubble_cnt   : bubbles inserted since reset, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module id_ex_pipeline_reg #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [31:0]     id_inst,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rd,
    input  logic [5:0]      id_ctrl,
    input  logic            stall,
    input  logic            flush,
    output logic            ex_valid,
    output logic [31:0]     ex_inst,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [5:0]      ex_ctrl,
    output logic [15:0]     bubble_cnt
);

    logic            valid_reg;
    logic [31:0]     inst_reg;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] rs1_data_reg;
    logic [XLEN-1:0] rs2_data_reg;
    logic [XLEN-1:0] imm_reg;
    logic [4:0]      rd_reg;
    logic [5:0]      ctrl_reg;
    logic [15:0]     bubble_cnt_reg;

    // Values written on a load. An invalid ID slot still loads its datapath
    // fields, but the instruction becomes a NOP and rd/ctrl are cleared so the
    // slot can never write a register, touch memory or halt.
    logic [31:0] load_inst_next;
    logic [4:0]  load_rd_next;
    logic [5:0]  load_ctrl_next;
    logic        bubble_event;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_ctrl_gate
            assign load_ctrl_next[gi] = id_ctrl[gi] & id_valid;
        end
        for (gi = 0; gi < 5; gi++) begin : g_rd_gate
            assign load_rd_next[gi] = id_rd[gi] & id_valid;
        end
    endgenerate

    assign load_inst_next = id_valid ? id_inst : NOP_INST;

    // A bubble is written by a flush (even while stalled) or by a load of an
    // empty ID slot. Stalled cycles write nothing and so never count.
    assign bubble_event = flush | (~stall & ~id_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg    <= 1'b0;
            inst_reg     <= NOP_INST;
            pc_reg       <= '0;
            rs1_data_reg <= '0;
            rs2_data_reg <= '0;
            imm_reg      <= '0;
            rd_reg       <= '0;
            ctrl_reg     <= '0;
        end else if (flush) begin
            // Flush beats stall: a squashed instruction must not linger in EX.
            valid_reg    <= 1'b0;
            inst_reg     <= NOP_INST;
            pc_reg       <= '0;
            rs1_data_reg <= '0;
            rs2_data_reg <= '0;
            imm_reg      <= '0;
            rd_reg       <= '0;
            ctrl_reg     <= '0;
        end else if (!stall) begin
            valid_reg    <= id_valid;
            inst_reg     <= load_inst_next;
            pc_reg       <= id_pc;
            rs1_data_reg <= id_rs1_data;
            rs2_data_reg <= id_rs2_data;
            imm_reg      <= id_imm;
            rd_reg       <= load_rd_next;
            ctrl_reg     <= load_ctrl_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_reg <= '0;
        end else if (bubble_event && (bubble_cnt_reg != 16'hFFFF)) begin
            bubble_cnt_reg <= bubble_cnt_reg + 16'd1;
        end
    end

    assign ex_valid    = valid_reg;
    assign ex_inst     = inst_reg;
    assign ex_pc       = pc_reg;
    assign ex_rs1_data = rs1_data_reg;
    assign ex_rs2_data = rs2_data_reg;
    assign ex_imm      = imm_reg;
    assign ex_rd       = rd_reg;
    assign ex_ctrl     = ctrl_reg;
    assign bubble_cnt  = bubble_cnt_reg;

    // Source indices come from the registered instruction, so a bubble (NOP)
    // reads x0/x0 and can never match a forwarding source.
    assign ex_rs1 = inst_reg[19:15];
    assign ex_rs2 = inst_reg[24:20];

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
module tb_id_ex_pipeline_reg;

    localparam int          XLEN = 32;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            reset;
    logic            id_valid;
    logic [31:0]     id_inst;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]      id_rd;
    logic [5:0]      id_ctrl;
    logic            stall, flush;
    logic            ex_valid;
    logic [31:0]     ex_inst;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [5:0]      ex_ctrl;
    logic [15:0]     bubble_cnt;

    always #5 clk = ~clk;

    id_ex_pipeline_reg #(.XLEN(XLEN), .NOP_INST(NOP)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_inst(id_inst),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rd(id_rd), .id_ctrl(id_ctrl), .stall(stall),
        .flush(flush), .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .bubble_cnt(bubble_cnt)
    );

    // Reference model: what EX should hold, described as plain fields.
    typedef struct {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rd;
        logic [5:0]  ctrl;
        int          cnt;
    } model_t;

    model_t m;
    int n_checks = 0;
    int n_errors = 0;

    function automatic void put_bubble_count();
        if (m.cnt < 65535) m.cnt = m.cnt + 1;
    endfunction

    // One clock edge of the documented behaviour.
    function automatic void model_edge();
        if (reset) begin
            m.valid = 1'b0; m.inst = NOP; m.pc = 0; m.rs1d = 0; m.rs2d = 0;
            m.imm = 0; m.rd = 0; m.ctrl = 0; m.cnt = 0;
        end else if (flush) begin
            m.valid = 1'b0; m.inst = NOP; m.pc = 0; m.rs1d = 0; m.rs2d = 0;
            m.imm = 0; m.rd = 0; m.ctrl = 0;
            put_bubble_count();
        end else if (!stall) begin
            m.valid = id_valid;
            m.pc    = id_pc;
            m.rs1d  = id_rs1_data;
            m.rs2d  = id_rs2_data;
            m.imm   = id_imm;
            if (id_valid) begin
                m.inst = id_inst; m.rd = id_rd; m.ctrl = id_ctrl;
            end else begin
                m.inst = NOP; m.rd = 0; m.ctrl = 0;
                put_bubble_count();
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] mi;
        mi = m.inst;
        check({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, m.valid});
        check({tag, ".inst"},  ex_inst, m.inst);
        check({tag, ".pc"},    ex_pc, m.pc);
        check({tag, ".rs1d"},  ex_rs1_data, m.rs1d);
        check({tag, ".rs2d"},  ex_rs2_data, m.rs2d);
        check({tag, ".imm"},   ex_imm, m.imm);
        check({tag, ".rs1"},   {27'd0, ex_rs1}, {27'd0, mi[19:15]});
        check({tag, ".rs2"},   {27'd0, ex_rs2}, {27'd0, mi[24:20]});
        check({tag, ".rd"},    {27'd0, ex_rd}, {27'd0, m.rd});
        check({tag, ".ctrl"},  {26'd0, ex_ctrl}, {26'd0, m.ctrl});
        check({tag, ".cnt"},   {16'd0, bubble_cnt}, m.cnt);
        $display("txn %s: valid=%0b inst=%h rd=%0d ctrl=%b cnt=%0d",
                 tag, ex_valid, ex_inst, ex_rd, ex_ctrl, bubble_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_id();
        id_valid    = 1'($urandom_range(0, 1));
        id_inst     = $urandom;
        id_pc       = $urandom;
        id_rs1_data = $urandom;
        id_rs2_data = $urandom;
        id_imm      = $urandom;
        id_rd       = 5'($urandom);
        id_ctrl     = 6'($urandom);
    endtask

    initial begin
        m = '{valid: 1'b0, inst: NOP, pc: 0, rs1d: 0, rs2d: 0, imm: 0, rd: 0, ctrl: 0, cnt: 0};
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        rand_id();

        // 1: reset for two cycles with random inputs
        repeat (2) begin
            #1; rand_id(); stall = 1'($urandom); flush = 1'($urandom);
            tick();
        end
        check_all("reset");
        check("reset.inst_const", ex_inst, 32'h0000_0013);
        check("reset.cnt_const", {16'd0, bubble_cnt}, 32'd0);
        reset = 1'b0; stall = 1'b0; flush = 1'b0;

        // 2: load sub x10,x10,x11
        id_valid = 1'b1; id_inst = 32'h40B5_0533; id_pc = 32'h10; id_rd = 5'd10;
        id_ctrl = 6'b010000; id_rs1_data = 32'h1111; id_rs2_data = 32'h2222; id_imm = 32'h0;
        tick();
        check_all("load_sub");
        check("load_sub.rs1_const", {27'd0, ex_rs1}, 32'd10);
        check("load_sub.rs2_const", {27'd0, ex_rs2}, 32'd11);
        check("load_sub.rd_const",  {27'd0, ex_rd},  32'd10);

        // 3: stall for three cycles while ID changes
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            tick();
            check_all("stall_hold");
            check("stall_hold.inst_const", ex_inst, 32'h40B5_0533);
        end

        // 4: stall and flush together -> bubble
        rand_id(); id_valid = 1'b1; stall = 1'b1; flush = 1'b1;
        tick();
        check_all("stall_flush");
        check("stall_flush.cnt_const", {16'd0, bubble_cnt}, 32'd1);
        stall = 1'b0; flush = 1'b0;

        // 5: invalid load with all control bits set
        rand_id(); id_valid = 1'b0; id_ctrl = 6'b111111;
        tick();
        check_all("invalid_load");
        check("invalid_load.ctrl_const", {26'd0, ex_ctrl}, 32'd0);
        check("invalid_load.cnt_const", {16'd0, bubble_cnt}, 32'd2);

        // random traffic, including the odd reset
        for (int i = 0; i < 300; i++) begin
            rand_id();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 49) == 0);
            tick();
            check_all("random");
        end
        reset = 1'b0; stall = 1'b0;

        // 6: drive the counter up to 16'hFFFE, then saturate
        flush = 1'b1;
        while (m.cnt < 65534) begin
            rand_id();
            stall = 1'($urandom);
            @(posedge clk);
            model_edge();
        end
        #1;
        check_all("near_sat");
        check("near_sat.cnt_const", {16'd0, bubble_cnt}, 32'h0000_FFFE);
        for (int i = 0; i < 4; i++) begin
            rand_id();
            tick();
            check_all("saturate");
            check("saturate.cnt_const", {16'd0, bubble_cnt}, 32'h0000_FFFF);
        end
        // an invalid load at saturation must not wrap either
        flush = 1'b0; stall = 1'b0; rand_id(); id_valid = 1'b0;
        tick();
        check_all("sat_invalid");

        // load a real instruction, stall, then reset mid-stall
        rand_id(); id_valid = 1'b1;
        tick();
        check_all("preload");
        stall = 1'b1; rand_id();
        tick();
        check_all("pre_reset_stall");
        reset = 1'b1; rand_id();
        tick();
        check_all("reset_mid_stall");
        check("reset_mid_stall.valid_const", {31'd0, ex_valid}, 32'd0);
        check("reset_mid_stall.inst_const", ex_inst, 32'h0000_0013);
        check("reset_mid_stall.cnt_const", {16'd0, bubble_cnt}, 32'd0);
        reset = 1'b0; stall = 1'b0;

        // first load right after reset deasserts
        rand_id(); id_valid = 1'b1;
        tick();
        check_all("post_reset_load");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
